// File: rtl/rst_staggered_channel_bank.sv
// Bank of NUM_CH capture registers whose channels are released one at a time
// after reset, STAGGER cycles apart, with per-channel clear/load and drop flags.
module rst_staggered_channel_bank #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int STAGGER = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       drop_flag,
  output logic                    release_done
);

  localparam int CW = $clog2(STAGGER) + 1;
  localparam int IW = $clog2(NUM_CH) + 1;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic           fire;
  logic [WIDTH-1:0] data_q [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    fire     = 1'b0;
    case (state)
      HOLD: begin
        state_nx = RELEASE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
      RELEASE: begin
        if (cnt == CW'(STAGGER - 1)) begin
          fire   = 1'b1;
          cnt_nx = '0;
          idx_nx = idx + IW'(1);
          if (idx == IW'(NUM_CH - 1)) state_nx = RUN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RUN:     state_nx = RUN;
      default: state_nx = HOLD;
    endcase
  end

  // RUN is entered on the same edge the last channel is released.
  assign release_done = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_active <= '0;
      drop_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (fire && idx == IW'(i)) ch_active[i] <= 1'b1;
        if (ch_active[i]) begin
          if (clear[i])     data_q[i] <= RESET_VAL;
          else if (load[i]) data_q[i] <= data_in[i*WIDTH +: WIDTH];
        end
        if (load[i] && !ch_active[i]) drop_flag[i] <= 1'b1;
        else if (clear[i])            drop_flag[i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign data_out[g*WIDTH +: WIDTH] = data_q[g];
  end

endmodule
